// File: rtl/ram_frame_ctrl.sv
// Frame capture/readout controller for a single-port BRAM with 2-cycle read latency.
// Captured pixels land at sequential addresses; readout streams them through a skid FIFO.
module ram_frame_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  start_capture,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  start_read,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  capture_done,
  output logic [ADDR_WIDTH:0]   frame_len,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_wea,
  output logic                  ram_ena,
  output logic                  ram_regcea,
  input  logic [DATA_WIDTH-1:0] ram_douta
);

  localparam int IW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int OW = CW + 2;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_L     = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READOUT, S_DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_frame_len, r_pop_idx;
  logic [1:0]            r_vld_pipe;
  logic [DATA_WIDTH-1:0] r_fifo [SKID_DEPTH];
  logic [IW-1:0]         r_wr_idx, r_rd_idx;
  logic [CW-1:0]         r_count;
  logic                  r_capture_done;

  logic                  w_accept, w_cap_end, w_issue, w_rd_end, w_push, w_pop;
  logic                  w_m_valid, w_m_last, w_start_cap, w_start_rd;
  logic [ADDR_WIDTH:0]   w_ptr_ext;
  logic [OW-1:0]         w_occ;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    return (i == IW'(SKID_DEPTH - 1)) ? '0 : i + IW'(1);
  endfunction

  assign w_ptr_ext   = {1'b0, r_ptr};
  assign w_start_cap = (r_state == S_IDLE) && start_capture;
  assign w_start_rd  = (r_state == S_IDLE) && !start_capture && start_read && (r_frame_len != '0);
  assign w_m_valid   = (r_count != '0);
  assign w_m_last    = w_m_valid && (r_pop_idx == r_frame_len - ONE_L);
  assign w_pop       = w_m_valid && m_ready;
  assign w_push      = r_vld_pipe[1];
  // Slots already spoken for: queued words plus reads still in the RAM pipeline.
  assign w_occ       = OW'(r_count) + OW'(r_vld_pipe[0]) + OW'(r_vld_pipe[1]) - OW'(w_pop);
  assign w_issue     = (r_state == S_READOUT) && (w_occ < OW'(SKID_DEPTH));
  assign w_rd_end    = w_issue && (w_ptr_ext == r_frame_len - ONE_L);
  assign w_accept    = (r_state == S_CAPTURE) && s_valid;
  assign w_cap_end   = w_accept && (s_last || (w_ptr_ext == LAST_ADDR));

  always_ff @(posedge clka) begin
    if (rsta) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ram_ena     = w_accept || w_issue;
    ram_wea     = w_accept;
    ram_addra   = (w_accept || w_issue) ? r_ptr : '0;
    ram_dina    = w_accept ? s_data : '0;
    ram_regcea  = (r_state == S_READOUT) || (r_state == S_DRAIN);
    s_ready     = (r_state == S_CAPTURE);
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start_capture)   w_state_nxt = S_CAPTURE;
        else if (w_start_rd) w_state_nxt = S_READOUT;
      end
      S_CAPTURE: if (w_cap_end)          w_state_nxt = S_IDLE;
      S_READOUT: if (w_rd_end)           w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_pop && w_m_last)  w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_ptr          <= '0;
      r_frame_len    <= '0;
      r_pop_idx      <= '0;
      r_vld_pipe     <= '0;
      r_wr_idx       <= '0;
      r_rd_idx       <= '0;
      r_count        <= '0;
      r_capture_done <= 1'b0;
    end else begin
      r_capture_done <= w_cap_end;
      r_vld_pipe     <= {r_vld_pipe[0], w_issue};
      if (w_start_cap) begin
        r_ptr       <= '0;
        r_frame_len <= '0;
      end else if (w_start_rd) begin
        r_ptr <= '0;
      end else if (w_accept) begin
        r_frame_len <= r_frame_len + ONE_L;
        if (!w_cap_end) r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end else if (w_issue && !w_rd_end) begin
        r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end
      if (w_start_rd) r_pop_idx <= '0;
      else if (w_pop) r_pop_idx <= r_pop_idx + ONE_L;
      if (w_push) r_wr_idx <= idx_inc(r_wr_idx);
      if (w_pop)  r_rd_idx <= idx_inc(r_rd_idx);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: entries are only visible while r_count says so.
  always_ff @(posedge clka) begin
    if (w_push) r_fifo[r_wr_idx] <= ram_douta;
  end

  assign m_valid      = w_m_valid;
  assign m_data       = w_m_valid ? r_fifo[r_rd_idx] : '0;
  assign m_last       = w_m_last;
  assign capture_done = r_capture_done;
  assign frame_len    = r_frame_len;

endmodule

// File: tb/tb_ram_frame_ctrl.sv
// Bench for ram_frame_ctrl: BRAM model, table-driven capture/readout runs with
// random data, gaps and backpressure, plus hand sequences for pulses and reset.
module tb_ram_frame_ctrl;
  localparam int DW = 18, DEPTH = 1024, AW = 10, SK = 4, MAXN = 1100;

  logic          clka = 1'b0;
  logic          rsta, start_capture, s_valid, s_last, s_ready, start_read;
  logic [DW-1:0] s_data, m_data, ram_dina, ram_douta;
  logic          m_valid, m_last, m_ready, busy, capture_done;
  logic [AW:0]   frame_len;
  logic [AW-1:0] ram_addra;
  logic          ram_wea, ram_ena, ram_regcea;

  always #5 clka = ~clka;

  ram_frame_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .SKID_DEPTH(SK)) dut (
    .clka(clka), .rsta(rsta), .start_capture(start_capture), .s_valid(s_valid),
    .s_data(s_data), .s_last(s_last), .s_ready(s_ready), .start_read(start_read),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .capture_done(capture_done), .frame_len(frame_len),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea), .ram_ena(ram_ena),
    .ram_regcea(ram_regcea), .ram_douta(ram_douta));

  // No-change single-port BRAM: array read, then output register.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q1;
  always @(posedge clka) begin
    if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      else         ram_q1 <= mem[ram_addra];
    end
    if (ram_regcea) ram_douta <= ram_q1;
  end

  typedef struct {
    int n; int last_idx; int gap; int seq; int rmode; int exp_len;
  } vec_t;
  vec_t vecs[6];

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] exp_data [MAXN];
  int exp_len, rx_idx, wr_cnt, exp_wr_addr, done_cnt, outstanding, max_out;
  int cyc, first_vld, last_hs;
  bit mon_en = 0, stall_prev = 0;
  logic [DW-1:0] stall_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic monitor();
    if (ram_wea) begin
      check("wea_only_in_capture", 32'(s_ready), 1);
      check("wr_addr", 32'(ram_addra), 32'(exp_wr_addr));
      if (exp_wr_addr < MAXN) check("wr_data", 32'(ram_dina), 32'(exp_data[exp_wr_addr]));
      exp_wr_addr++;
      wr_cnt++;
    end
    if (capture_done) done_cnt++;
    if (ram_ena && !ram_wea) outstanding++;
    if (stall_prev) begin
      check("m_valid_held", 32'(m_valid), 1);
      check("m_data_held", 32'(m_data), 32'(stall_data));
    end
    if (m_valid && first_vld < 0) first_vld = cyc;
    if (m_valid) check("m_last", 32'(m_last), 32'(rx_idx == exp_len - 1));
    if (m_valid && m_ready) begin
      if (rx_idx < exp_len) check("m_data", 32'(m_data), 32'(exp_data[rx_idx]));
      else check("extra_word", 32'(rx_idx), 32'(exp_len - 1));
      rx_idx++;
      outstanding--;
      last_hs = cyc;
    end
    if (outstanding > max_out) max_out = outstanding;
    stall_prev = m_valid && !m_ready;
    stall_data = m_data;
    cyc++;
  endtask

  task automatic tick();
    #1;
    if (mon_en) monitor();
    @(negedge clka);
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom_range(1));
    endcase
  endfunction

  task automatic capture(input int n, input int last_idx, input int gap, input int seq,
                         input bit also_read, input int elen);
    for (int i = 0; i < n; i++) exp_data[i] = seq ? DW'(i + 1) : DW'($urandom());
    exp_len = elen; wr_cnt = 0; exp_wr_addr = 0; done_cnt = 0; outstanding = 0;
    start_capture = 1'b1; start_read = also_read;
    tick();
    start_capture = 1'b0; start_read = 1'b0;
    check("cap_s_ready", 32'(s_ready), 1);
    check("cap_no_regce", 32'(ram_regcea), 0);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < gap) begin
        s_valid = 1'b0; tick();
      end
      s_valid = 1'b1; s_data = exp_data[i]; s_last = (i == last_idx);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    tick(); tick();
    check("cap_writes", 32'(wr_cnt), 32'(elen));
    check("cap_done_pulses", 32'(done_cnt), 1);
    check("cap_frame_len", 32'(frame_len), 32'(elen));
    check("cap_s_ready_low", 32'(s_ready), 0);
    check("cap_no_reads", 32'(outstanding), 0);
  endtask

  task automatic readout(input int mode);
    int k;
    rx_idx = 0; outstanding = 0; max_out = 0; first_vld = -1; last_hs = -1; cyc = 0;
    stall_prev = 0;
    start_read = 1'b1; m_ready = rdy(mode, 0);
    tick();
    start_read = 1'b0;
    k = 1;
    while (rx_idx < exp_len && k < exp_len * 6 + 40) begin
      m_ready = rdy(mode, k);
      tick();
      k++;
    end
    check("rd_words", 32'(rx_idx), 32'(exp_len));
    check("rd_busy_after", 32'(busy), 0);
    check("rd_m_valid_after", 32'(m_valid), 0);
    check("rd_occupancy_le_skid", 32'(max_out <= SK), 1);
    if (mode == 0) begin
      check("rd_first_valid_cycle", 32'(first_vld), 4);
      check("rd_last_hs_cycle", 32'(last_hs), 32'(exp_len + 3));
    end
    m_ready = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{8, 7, 0, 1, 0, 8};
    vecs[1] = '{8, 7, 30, 1, 1, 8};
    vecs[2] = '{1100, -1, 10, 0, 2, 1024};
    vecs[3] = '{6, 2, 20, 0, 0, 3};
    vecs[4] = '{1, 0, 0, 0, 1, 1};
    vecs[5] = '{1030, 1029, 0, 0, 0, 1024};

    rsta = 1'b1; start_capture = 0; start_read = 0; s_valid = 0; s_last = 0;
    s_data = '0; m_ready = 0; exp_len = 0; rx_idx = 0;
    @(negedge clka); @(negedge clka); @(negedge clka);
    rsta = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_capture_done", 32'(capture_done), 0);
    check("rst_frame_len", 32'(frame_len), 0);
    check("rst_ram_ena", 32'(ram_ena), 0);
    check("rst_ram_wea", 32'(ram_wea), 0);
    check("rst_ram_regcea", 32'(ram_regcea), 0);
    @(negedge clka);
    mon_en = 1;

    start_read = 1'b1; tick(); start_read = 1'b0; tick();
    check("len0_read_ignored", 32'(busy), 0);

    foreach (vecs[v]) begin
      capture(vecs[v].n, vecs[v].last_idx, vecs[v].gap, vecs[v].seq, 1'b0, vecs[v].exp_len);
      readout(vecs[v].rmode);
    end

    // Simultaneous pulses: capture must win and no reads may be issued.
    capture(2, 1, 0, 1, 1'b1, 2);
    readout(0);

    // Reset three words into a readout.
    capture(8, 7, 0, 1, 1'b0, 8);
    rx_idx = 0; outstanding = 0; first_vld = -1; cyc = 0;
    start_read = 1'b1; m_ready = 1'b1; tick(); start_read = 1'b0;
    for (int k = 0; k < 20 && rx_idx < 3; k++) tick();
    check("pre_rst_words", 32'(rx_idx), 3);
    m_ready = 1'b0; rsta = 1'b1; tick(); rsta = 1'b0;
    outstanding = 0; stall_prev = 0;
    check("midrst_m_valid", 32'(m_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_frame_len", 32'(frame_len), 0);
    start_read = 1'b1; tick(); start_read = 1'b0; tick();
    check("post_rst_read_ignored", 32'(busy), 0);
    check("post_rst_no_valid", 32'(m_valid), 0);
    tick(); tick();
    check("post_rst_no_reads", 32'(outstanding), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
